// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter: round-robin share of the RF write port + RAW board    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module regfile_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*AW-1:0]     req_rd_i,
  input  logic [N_REQ*XLEN-1:0]   req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic                    iss_valid_i,
  input  logic [AW-1:0]           iss_rd_i,
  input  logic [AW-1:0]           rs1_i,
  input  logic [AW-1:0]           rs2_i,
  output logic                    rs1_busy_o,
  output logic                    rs2_busy_o,
  output logic                    rf_we_o,
  output logic [AW-1:0]           rf_rd_o,
  output logic [XLEN-1:0]         rf_wd_o,
  output logic [$clog2(N_REQ)-1:0] grant_id_o
);

  localparam int IDW  = $clog2(N_REQ);
  localparam int NREG = 1 << AW;

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            rf_we_q;
  logic [AW-1:0]   rf_rd_q;
  logic [XLEN-1:0] rf_wd_q;
  logic [IDW-1:0]  grant_id_q;
  logic [NREG-1:0] pending_q, pending_d;

  logic             gnt_valid;
  logic [IDW-1:0]   gnt_idx;
  logic [N_REQ-1:0] gnt_vec;
  logic [AW-1:0]    sel_rd;
  logic [XLEN-1:0]  sel_data;

  // Rotating priority search starting at rr_ptr; no grant is issued during reset.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_vec   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_valid && req_valid_i[IDW'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
    if (reset) gnt_valid = 1'b0;
    if (gnt_valid) gnt_vec[gnt_idx] = 1'b1;
  end

  assign sel_rd   = req_rd_i[int'(gnt_idx)*AW +: AW];
  assign sel_data = req_data_i[int'(gnt_idx)*XLEN +: XLEN];
  assign rr_ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + IDW'(1);

  // Set beats clear: a freshly issued producer owns the register again.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) pending_d[rf_rd_q] = 1'b0;
    if (iss_valid_i && (iss_rd_i != '0)) pending_d[iss_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wd_q    <= '0;
      grant_id_q <= '0;
      pending_q  <= '0;
    end else begin
      rf_we_q   <= gnt_valid && (sel_rd != '0);
      pending_q <= pending_d;
      if (gnt_valid) begin
        rf_rd_q    <= sel_rd;
        rf_wd_q    <= sel_data;
        grant_id_q <= gnt_idx;
        rr_ptr_q   <= rr_ptr_d;
      end
    end
  end

  assign req_ready_o = gnt_vec;
  assign rs1_busy_o  = pending_q[rs1_i];
  assign rs2_busy_o  = pending_q[rs2_i];
  assign rf_we_o     = rf_we_q;
  assign rf_rd_o     = rf_rd_q;
  assign rf_wd_o     = rf_wd_q;
  assign grant_id_o  = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

  localparam int N_REQ = 3;
  localparam int XLEN  = 32;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*AW-1:0]   req_rd;
  logic [N_REQ*XLEN-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;
  logic                  iss_valid;
  logic [AW-1:0]         iss_rd, rs1, rs2;
  logic                  rs1_busy, rs2_busy;
  logic                  rf_we;
  logic [AW-1:0]         rf_rd;
  logic [XLEN-1:0]       rf_wd;
  logic [1:0]            grant_id;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.N_REQ(N_REQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_rd_i    (req_rd),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .rs1_busy_o  (rs1_busy),
    .rs2_busy_o  (rs2_busy),
    .rf_we_o     (rf_we),
    .rf_rd_o     (rf_rd),
    .rf_wd_o     (rf_wd),
    .grant_id_o  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    req_valid[i]            = v;
    req_rd[i*AW +: AW]      = rd;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;

    // Reset with every requester valid; then a held 3-way contention.
    set_req(0, 1'b1, 5'd1, 32'hA0A0_0001);
    set_req(1, 1'b1, 5'd2, 32'hB1B1_0002);
    set_req(2, 1'b1, 5'd3, 32'hC2C2_0003);
    #1;
    chk("rst_ready_a", 64'(req_ready), 64'd0);
    tick();
    chk("rst_ready_b", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b0;
    rs1 = 5'd1;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_ready", 64'(req_ready), 64'(3'b001 << (k % 3)));
      if (k == 0) begin
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_wd", 64'(rf_wd), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_busy", 64'(rs1_busy), 64'd0);
      end else begin
        chk("rr_we", 64'(rf_we), 64'd1);
        chk("rr_rd", 64'(rf_rd), 64'(((k - 1) % 3) + 1));
      end
      tick();
    end
    req_valid = '0;
    #1;
    chk("rr_last_we", 64'(rf_we), 64'd1);
    chk("rr_last_rd", 64'(rf_rd), 64'd3);
    chk("rr_last_wd", 64'(rf_wd), 64'hC2C2_0003);
    chk("rr_last_gid", 64'(grant_id), 64'd2);
    chk("idle_ready", 64'(req_ready), 64'd0);
    tick();
    chk("idle_we", 64'(rf_we), 64'd0);
    chk("idle_rd_hold", 64'(rf_rd), 64'd3);

    // Single requester 1, then rr_ptr=2 must favour req2 over req0.
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("r1_ready", 64'(req_ready), 64'b010);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    set_req(0, 1'b1, 5'd0, 32'h0000_1234);
    set_req(2, 1'b1, 5'd6, 32'h0000_6666);
    #1;
    chk("r1_we", 64'(rf_we), 64'd1);
    chk("r1_rd", 64'(rf_rd), 64'd5);
    chk("r1_wd", 64'(rf_wd), 64'hDEADBEEF);
    chk("r1_gid", 64'(grant_id), 64'd1);
    chk("ptr2_ready", 64'(req_ready), 64'b100);
    tick();
    req_valid[2] = 1'b0;
    #1;
    chk("r2_rd", 64'(rf_rd), 64'd6);
    chk("rd0_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid[0] = 1'b0;
    rs1 = 5'd0;
    #1;
    chk("rd0_we", 64'(rf_we), 64'd0);
    chk("rd0_gid", 64'(grant_id), 64'd0);
    chk("rs0_busy", 64'(rs1_busy), 64'd0);

    // RAW tracking on rd 7: busy until the write edge, clear once readable.
    iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    chk("r7_busy_t", 64'(rs1_busy), 64'd0);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("r7_busy_t1", 64'(rs1_busy), 64'd1);
    chk("r7_busy2_t1", 64'(rs2_busy), 64'd1);
    tick();
    chk("r7_busy_t2", 64'(rs1_busy), 64'd1);
    tick();
    set_req(2, 1'b1, 5'd7, 32'h0000_0077);
    #1;
    chk("r7_ready", 64'(req_ready), 64'b100);
    chk("r7_busy_t3", 64'(rs1_busy), 64'd1);
    tick();
    req_valid[2] = 1'b0;
    #1;
    chk("r7_we", 64'(rf_we), 64'd1);
    chk("r7_rd", 64'(rf_rd), 64'd7);
    chk("r7_busy_t4", 64'(rs1_busy), 64'd1);
    tick();
    chk("r7_busy_t5", 64'(rs1_busy), 64'd0);
    chk("r7_we_t5", 64'(rf_we), 64'd0);

    // Same-edge set and clear of rd 9: set wins; then reset mid-stream.
    iss_valid = 1'b1; iss_rd = 5'd9; rs1 = 5'd9;
    tick();
    iss_valid = 1'b0;
    set_req(0, 1'b1, 5'd9, 32'h0000_0099);
    #1;
    chk("r9_ready", 64'(req_ready), 64'b001);
    chk("r9_busy_a", 64'(rs1_busy), 64'd1);
    tick();
    req_valid[0] = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    chk("r9_we", 64'(rf_we), 64'd1);
    chk("r9_rd", 64'(rf_rd), 64'd9);
    tick();
    iss_valid = 1'b1; iss_rd = 5'd12; rs2 = 5'd0;
    #1;
    chk("r9_set_wins", 64'(rs1_busy), 64'd1);
    chk("rs2_zero_busy", 64'(rs2_busy), 64'd0);
    tick();
    iss_valid = 1'b0; rs2 = 5'd12;
    #1;
    chk("r12_busy", 64'(rs2_busy), 64'd1);
    reset = 1'b1;
    set_req(1, 1'b1, 5'd4, 32'h0000_0044);
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b0;
    req_valid = 3'b011;
    #1;
    chk("mid_rst_we", 64'(rf_we), 64'd0);
    chk("mid_rst_busy9", 64'(rs1_busy), 64'd0);
    chk("mid_rst_busy12", 64'(rs2_busy), 64'd0);
    chk("mid_rst_gid", 64'(grant_id), 64'd0);
    chk("mid_rst_ptr", 64'(req_ready), 64'b001);
    req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
